// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction/number one-hot codes, PS/2 scan codes and frame FSM states
package snake_pkg;

  localparam logic [4:0] DIR_NONE  = 5'b00000;
  localparam logic [4:0] DIR_UP    = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_DOWN  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;

  localparam logic [4:0] NUM_NONE = 5'b00000;
  localparam logic [4:0] NUM_1    = 5'b00010;
  localparam logic [4:0] NUM_2    = 5'b00100;
  localparam logic [4:0] NUM_3    = 5'b01000;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic [4:0] arrow_dir(input logic [7:0] code);
    case (code)
      SC_UP:    return DIR_UP;
      SC_LEFT:  return DIR_LEFT;
      SC_DOWN:  return DIR_DOWN;
      SC_RIGHT: return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

  function automatic logic [4:0] num_code(input logic [7:0] code);
    case (code)
      SC_1:    return NUM_1;
      SC_2:    return NUM_2;
      SC_3:    return NUM_3;
      default: return NUM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - PS/2 pins in, decoded key state out
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [4:0] direction;
  logic [4:0] number;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  direction, number, key_valid, key_code, key_break, key_ext, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output direction, number, key_valid, key_code, key_break, key_ext, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 synchronizer, falling-edge detect, 11-bit frame FSM and timeout
// PS2_PARITY_CHECK_EN enables the odd-parity check on received frames.
module ps2_frame_rx
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       timeout
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;
  rx_state_t              state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   parity_bit;
  logic [15:0]            tcnt;
  logic                   parity_ok;
  logic                   stop_edge;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{parity_bit, shift};
`else
  // parity is captured but deliberately has no effect on acceptance
  assign parity_ok = parity_bit | 1'b1;
`endif

  assign stop_edge  = fall && (state == RX_STOP);
  assign timeout    = (state != RX_IDLE) && !fall && (tcnt == TO_LIM);
  assign byte_valid = stop_edge && dat_s && parity_ok;
  assign frame_err  = (stop_edge && !(dat_s && parity_ok)) || timeout;
  assign byte_data  = shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      clk_prev   <= 1'b1;
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tcnt       <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;

      if (fall) tcnt <= '0;
      else if (tcnt != TO_LIM) tcnt <= tcnt + 16'd1;

      if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat_s) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_bit <= dat_s;
            state      <= RX_STOP;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (timeout) begin
        state <= RX_IDLE;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard front end: E0/F0 prefix resolution, held direction and number codes
// PS2_PARITY_CHECK_EN (in ps2_frame_rx) makes bad-parity frames raise frame_err.
module ps2_key_decoder
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input logic             clk,
  input logic             reset,
  ps2_key_decoder_if.slave bus
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       rx_timeout;
  logic       ext_f;
  logic       brk_f;
  logic [4:0] direction;
  logic [4:0] number;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       frame_err;
  logic [4:0] arrow;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (bus.ps2_clk),
    .ps2_dat   (bus.ps2_dat),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_err),
    .timeout   (rx_timeout)
  );

  assign arrow = arrow_dir(rx_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      direction <= DIR_NONE;
      number    <= NUM_NONE;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_break <= 1'b0;
      key_ext   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= rx_err;
      if (rx_timeout) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == SC_EXT) begin
          ext_f <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk_f <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= rx_byte;
          key_break <= brk_f;
          key_ext   <= ext_f;
          ext_f     <= 1'b0;
          brk_f     <= 1'b0;
          // releasing an arrow other than the held one must not clear direction
          if (ext_f && !brk_f && arrow != DIR_NONE) direction <= arrow;
          else if (ext_f && brk_f && arrow != DIR_NONE && arrow == direction) direction <= DIR_NONE;
          if (!ext_f && brk_f) number <= num_code(rx_byte);
        end
      end
    end
  end

  assign bus.direction = direction;
  assign bus.number    = number;
  assign bus.key_valid = key_valid;
  assign bus.key_code  = key_code;
  assign bus.key_break = key_break;
  assign bus.key_ext   = key_ext;
  assign bus.frame_err = frame_err;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Synchronous PS/2 keyboard front end for the snake game. It samples the raw `PS2_CLK`/`PS2_DAT` pins in the `CLOCK_50` domain and frames 11-bit packets. It resolves the `E0` (extended) and `F0` (break) prefixes and produces the held one-hot `direction` and `number` codes consumed by the game datapath and `Controller`. The sub-module names `snake_pkg` and `ps2_frame_rx` are new and must not collide with existing modules.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles (1 ms at 50 MHz) after which a partial frame is abandoned.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizer; legal values are ≥2.

Ports:
- `clk`, in, 1: system clock (`CLOCK_50`).
- `reset`, in, 1: synchronous, active-high reset.
- `ps2_clk`, in, 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_dat`, in, 1: raw PS/2 data pin, asynchronous to `clk`.
- `direction`, out, 5: held arrow code. UP=00010, LEFT=00100, DOWN=01000, RIGHT=10000, none=00000.
- `number`, out, 5: held digit code, latched on key release. "1"=00010, "2"=00100, "3"=01000, other=00000.
- `key_valid`, out, 1: one-cycle pulse for every accepted complete scan-code sequence (make or break).
- `key_code`, out, 8: final byte of the last accepted sequence. Valid while `key_valid` is high and held afterwards.
- `key_break`, out, 1: high if the last accepted sequence was a break.
- `key_ext`, out, 1: high if the last accepted sequence was extended.
- `frame_err`, out, 1: one-cycle pulse when a frame is discarded.

## Operation
- **Synchronizer:** `ps2_clk` and `ps2_dat` each pass through `SYNC_STAGES` flops. A falling edge is detected on the synchronized clock (previous=1, current=0). Data is sampled on that edge.
- **Frame FSM** (`ps2_frame_rx`):
  - IDLE: a falling edge with data=0 moves to DATA. If data=1, the edge is ignored (bad start).
  - DATA: 8 bits, LSB first, with a 3-bit counter. Moves to PARITY after the 8th bit.
  - PARITY: captures the parity bit, then moves to STOP.
  - STOP: if stop=1, plus the parity check when configured, emit the byte and return to IDLE. Otherwise pulse `frame_err` and return to IDLE.
- **Timeout:** a 16-bit counter restarts on every falling edge. Reaching `TIMEOUT_CYCLES` in any state except IDLE returns the FSM to IDLE, clears the prefix flags and pulses `frame_err`.
- **Byte decoder:**
  - Byte `E0` sets `ext_f`.
  - Byte `F0` sets `brk_f`.
  - Any other byte completes a sequence: drive `key_valid`, `key_code`, `key_break`=`brk_f` and `key_ext`=`ext_f`, then clear both flags.
- **Direction:**
  - Extended make of `75`/`6B`/`72`/`74` sets `direction` to UP/LEFT/DOWN/RIGHT respectively.
  - Extended break of the arrow currently held clears `direction` to 0.
  - Breaks of other arrows, and all non-arrow keys, leave `direction` unchanged.
  - A typematic repeat re-latches the same value.
- **Number:** every non-extended break updates `number`. `16`→00010, `1E`→00100, `26`→01000, any other code→00000. Make codes never change `number`.
- **Reset:** abandons any frame or prefix in progress. On the cycle after `reset` is sampled high, every output is 0, including `direction`, `number`, `key_code`, all flags and all pulses.

## Timing
- Pin to detected edge: `SYNC_STAGES`+1 `clk` cycles.
- `key_valid`, `direction` and `number` update together, exactly one cycle after the stop-bit edge is detected.
- `frame_err` is asserted in that same cycle, or in the cycle the timeout counter expires.
- A new start bit arriving in the cycle the previous byte completes is accepted; there are no dead cycles between frames.
- An edge and a timeout in the same cycle: the edge wins and the counter restarts.
- A `reset` coincident with a completing frame: reset wins and no pulse is emitted.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the frame must satisfy odd parity (the 8 data bits plus the parity bit contain an odd number of 1s). A bad frame is dropped, pulses `frame_err` and leaves the prefix flags intact.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is captured and ignored, and only a stop bit of 0 raises `frame_err`.

## Structure
- Package `snake_pkg`:
  - One-hot direction constants: `DIR_NONE`, `DIR_UP`, `DIR_LEFT`, `DIR_DOWN`, `DIR_RIGHT`.
  - Number constants: `NUM_1`, `NUM_2`, `NUM_3`.
  - Scan-code constants: `SC_UP`=`75`, `SC_LEFT`=`6B`, `SC_DOWN`=`72`, `SC_RIGHT`=`74`, `SC_1`=`16`, `SC_2`=`1E`, `SC_3`=`26`, `SC_EXT`=`E0`, `SC_BRK`=`F0`.
  - Frame FSM state encoding.
- Sub-module `ps2_frame_rx`: contains the synchronizer, edge detect, frame FSM and timeout. It outputs `byte_valid`, `byte_data` and `frame_err`.
- The top of `ps2_key_decoder` holds the prefix flags and the output registers.

## Test plan
- **Up arrow press and release:** send `E0 75`, then `E0 F0 75` (~10 kHz PS/2 clock). `direction`=00010 after the `75` frame and 00000 after the break. `key_valid` pulses twice, with `key_ext`=1 both times.
- **Digit release:** send `1E`, then `F0 1E`. `number` stays 00000 after the make and becomes 00100 after the break. Then `F0 29` clears `number` to 00000.
- **Arrow overlap:** send `E0 6B` then `E0 74`, so `direction`=10000. Then `E0 F0 6B` leaves `direction` at 10000, and `E0 F0 74` clears it to 00000.
- **Parity error** (with `PS2_PARITY_CHECK_EN`): send `75` with a flipped parity bit. `frame_err` pulses, `direction` is unchanged and there is no `key_valid`. A following good `E0 72` gives 01000.
- **Timeout:** stop the PS/2 clock after 4 data bits for more than 50000 cycles. `frame_err` pulses once and the FSM returns to IDLE. A following good `E0 75` decodes correctly.
- **Reset mid-frame:** assert `reset` for 1 cycle during bit 5 of `75`, after `direction`=01000 was already held. All outputs read 0 the next cycle, and no `key_valid` occurs for the truncated frame.
